// File: rtl/jtgng_unamiga_dwnld.sv
// ROM download sequencer: packs ioctl bytes into 16-bit words, buffers them in a
// small FIFO and writes them to SDRAM with a req/ack handshake.
module jtgng_unamiga_dwnld #(
    parameter int AW        = 22,
    parameter int FIFO_LOG2 = 2,
    parameter bit SWAP      = 1'b0
) (
    input  logic          clk_rom,
    input  logic          rst,
    input  logic          downloading,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [7:0]    ioctl_data,
    input  logic          ioctl_wr,
    output logic          sdram_req,
    input  logic          sdram_ack,
    output logic [AW-2:0] sdram_addr,
    output logic [15:0]   sdram_din,
    output logic [1:0]    sdram_wrmask,
    output logic          rst_game,
    output logic          dwn_done,
    output logic          overflow
);
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0] PTR_ONE = 1;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    typedef struct packed {
        logic [AW-2:0] addr;
        logic [15:0]   din;
        logic [1:0]    mask;
    } word_t;

    localparam word_t OUT_RST = '{addr: '0, din: '0, mask: 2'b11};

    state_t             state_q, state_d;
    logic               loaded_q, loaded_d;
    logic               overflow_q, overflow_d;
    logic               pend_valid_q, pend_valid_d;
    logic               pend_odd_q, pend_odd_d;
    logic [AW-2:0]      pend_waddr_q, pend_waddr_d;
    logic [7:0]         pend_byte_q, pend_byte_d;
    logic [FIFO_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic               req_q, req_d;
    word_t              out_q, out_d;
    word_t              mem_q [DEPTH];

    logic               push, do_write, pop, empty, full;
    word_t              push_word;

    // A lone byte lands on its lane; the other lane is masked off (mask is active-low).
    function automatic word_t half_word(input logic [AW-2:0] waddr, input logic [7:0] b,
                                        input logic odd);
        word_t w;
        w.addr = waddr;
        if (odd ^ SWAP) begin
            w.din  = {b, 8'h00};
            w.mask = 2'b01;
        end else begin
            w.din  = {8'h00, b};
            w.mask = 2'b10;
        end
        return w;
    endfunction

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[FIFO_LOG2] != rd_ptr_q[FIFO_LOG2]) &&
                   (wr_ptr_q[FIFO_LOG2-1:0] == rd_ptr_q[FIFO_LOG2-1:0]);
    assign pop   = req_q & sdram_ack;

    // NOTE: every signal gets its default first so no path through this block infers a latch.
    always_comb begin
        state_d      = state_q;
        loaded_d     = loaded_q;
        overflow_d   = overflow_q;
        pend_valid_d = pend_valid_q;
        pend_odd_d   = pend_odd_q;
        pend_waddr_d = pend_waddr_q;
        pend_byte_d  = pend_byte_q;
        push         = 1'b0;
        push_word    = OUT_RST;

        unique case (state_q)
            IDLE: if (downloading) begin
                state_d      = LOAD;
                overflow_d   = 1'b0;
                pend_valid_d = 1'b0;
            end
            LOAD: if (!downloading) state_d = FLUSH;
            FLUSH: begin
                if (pend_valid_q) begin
                    push         = 1'b1;
                    push_word    = half_word(pend_waddr_q, pend_byte_q, pend_odd_q);
                    pend_valid_d = 1'b0;
                end else if (empty && !req_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d  = IDLE;
                loaded_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // The strobe is taken on the falling-downloading cycle too, ahead of the flush.
        if (state_q == LOAD && ioctl_wr) begin
            if (!ioctl_addr[0]) begin
                if (pend_valid_q) begin
                    push      = 1'b1;
                    push_word = half_word(pend_waddr_q, pend_byte_q, pend_odd_q);
                end
                pend_valid_d = 1'b1;
                pend_odd_d   = 1'b0;
                pend_waddr_d = ioctl_addr[AW-1:1];
                pend_byte_d  = ioctl_data;
            end else if (pend_valid_q && !pend_odd_q && pend_waddr_q == ioctl_addr[AW-1:1]) begin
                push           = 1'b1;
                push_word.addr = pend_waddr_q;
                push_word.din  = SWAP ? {pend_byte_q, ioctl_data} : {ioctl_data, pend_byte_q};
                push_word.mask = 2'b00;
                pend_valid_d   = 1'b0;
            end else if (pend_valid_q) begin
                // Only one push per cycle: the stray odd byte waits as the new pending byte.
                push         = 1'b1;
                push_word    = half_word(pend_waddr_q, pend_byte_q, pend_odd_q);
                pend_odd_d   = 1'b1;
                pend_waddr_d = ioctl_addr[AW-1:1];
                pend_byte_d  = ioctl_data;
            end else begin
                push      = 1'b1;
                push_word = half_word(ioctl_addr[AW-1:1], ioctl_data, 1'b1);
            end
        end

        // A pop frees the slot in the same cycle, so a push onto a full FIFO survives it.
        do_write = push & (~full | pop);
        if (push && !do_write) overflow_d = 1'b1;

        wr_ptr_d = do_write ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        req_d = req_q;
        out_d = out_q;
        if (pop) begin
            req_d = 1'b0;
        end else if (!req_q && !empty) begin
            req_d = 1'b1;
            out_d = mem_q[rd_ptr_q[FIFO_LOG2-1:0]];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_rom) begin
        if (rst) begin
            state_q      <= IDLE;
            loaded_q     <= 1'b0;
            overflow_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_odd_q   <= 1'b0;
            pend_waddr_q <= '0;
            pend_byte_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            req_q        <= 1'b0;
            out_q        <= OUT_RST;
        end else begin
            state_q      <= state_d;
            loaded_q     <= loaded_d;
            overflow_q   <= overflow_d;
            pend_valid_q <= pend_valid_d;
            pend_odd_q   <= pend_odd_d;
            pend_waddr_q <= pend_waddr_d;
            pend_byte_q  <= pend_byte_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            req_q        <= req_d;
            out_q        <= out_d;
        end
    end

    // NOTE: FIFO storage has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk_rom) begin
        if (do_write) mem_q[wr_ptr_q[FIFO_LOG2-1:0]] <= push_word;
    end

    assign sdram_req    = req_q;
    assign sdram_addr   = out_q.addr;
    assign sdram_din    = out_q.din;
    assign sdram_wrmask = out_q.mask;
    assign rst_game     = ~loaded_q | (state_q != IDLE);
    assign dwn_done     = (state_q == DONE);
    assign overflow     = overflow_q;

endmodule
